// File: rtl/v_pkg.sv
// Shared types and default sizing for the state-table access path.
package v_pkg;

    typedef logic [7:0]  id_t;
    typedef logic [3:0]  level_t;
    typedef logic [15:0] key_t;
    typedef logic [31:0] volume_t;

    typedef enum logic [1:0] {
        CMD_ADD = 2'd0,
        CMD_MOD = 2'd1,
        CMD_DEL = 2'd2,
        CMD_CLR = 2'd3
    } cmd_t;

    typedef struct packed {
        id_t     prod_id;
        cmd_t    cmd;
        key_t    key;
        volume_t volume;
    } upd_t;

    localparam int UPD_FIFO_N_DFLT = 4;
    localparam int STARVE_N_DFLT   = 8;

endpackage

// File: rtl/v_upd_fifo.sv
// Synchronous FIFO holding buffered updates; head is the registered oldest entry.
module v_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Full is judged on the registered count, so a pop never makes room in its own cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/v_state_arb.sv
// Arbitrates the state-table read port between queries (default winner) and buffered updates.
module v_state_arb
    import v_pkg::*;
#(
    parameter int UPD_FIFO_N = UPD_FIFO_N_DFLT,
    parameter int STARVE_N   = STARVE_N_DFLT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_qry_vld,
    input  id_t     i_qry_prod_id,
    input  level_t  i_qry_level,
    output logic    o_qry_rdy,
    input  logic    i_upd_vld,
    input  id_t     i_upd_prod_id,
    input  cmd_t    i_upd_cmd,
    input  key_t    i_upd_key,
    input  volume_t i_upd_volume,
    output logic    o_upd_rdy,
    output logic    o_lut_vld_r,
    output id_t     o_lut_prod_id_r,
    output level_t  o_lut_level_r,
    output logic    o_upd_vld_r,
    output id_t     o_upd_prod_id_r,
    output cmd_t    o_upd_cmd_r,
    output key_t    o_upd_key_r,
    output volume_t o_upd_volume_r,
    output logic    o_busy
);

    localparam int SW = (STARVE_N > 1) ? $clog2(STARVE_N) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_N - 1);

    // Handshakes: a transfer happens on a cycle where vld && rdy; the source keeps
    // vld and payload steady until that cycle. rdy never depends on the same-cycle push.
    upd_t          upd_in;
    upd_t          upd_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [SW-1:0] starve_cnt;
    logic          upd_forced;
    logic          qry_issue;
    logic          upd_issue;

    assign upd_in = '{prod_id: i_upd_prod_id, cmd: i_upd_cmd, key: i_upd_key, volume: i_upd_volume};

    v_upd_fifo #(
        .DEPTH (UPD_FIFO_N),
        .W     ($bits(upd_t))
    ) u_upd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_upd_vld),
        .pop   (upd_issue),
        .din   (upd_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (upd_head)
    );

    assign upd_forced = i_qry_vld && !fifo_empty && (starve_cnt == STARVE_MAX);
    assign qry_issue  = i_qry_vld && !upd_forced;
    assign upd_issue  = !fifo_empty && (!i_qry_vld || upd_forced);
    assign o_qry_rdy  = !upd_forced;
    assign o_upd_rdy  = !fifo_full;
    assign o_busy     = !fifo_empty || o_lut_vld_r || o_upd_vld_r;

    // Counts queries that beat a waiting head; an idle FIFO or any update issue restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (upd_issue || fifo_empty) begin
            starve_cnt <= '0;
        end else if (qry_issue) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_lut_vld_r <= 1'b0;
            o_upd_vld_r <= 1'b0;
        end else begin
            o_lut_vld_r <= qry_issue;
            o_upd_vld_r <= upd_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (qry_issue) begin
            o_lut_prod_id_r <= i_qry_prod_id;
            o_lut_level_r   <= i_qry_level;
        end
        if (upd_issue) begin
            o_upd_prod_id_r <= upd_head.prod_id;
            o_upd_cmd_r     <= upd_head.cmd;
            o_upd_key_r     <= upd_head.key;
            o_upd_volume_r  <= upd_head.volume;
        end
    end

    a_one_issue: assert property (@(posedge clk) disable iff (!rst_n)
        !(o_lut_vld_r && o_upd_vld_r));

endmodule

// File: tb/tb_v_state_arb.sv
// Directed and random checks of v_state_arb against a queue-based scoreboard.
module tb_v_state_arb;
    import v_pkg::*;

    localparam int FN = 4;
    localparam int SN = 8;
    localparam int LW = $bits(id_t) + $bits(level_t);
    localparam int UW = $bits(upd_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic    qry_vld = 1'b0;
    id_t     qry_id = '0;
    level_t  qry_level = '0;
    logic    o_qry_rdy;
    logic    upd_vld = 1'b0;
    id_t     upd_id = '0;
    cmd_t    upd_cmd = CMD_ADD;
    key_t    upd_key = '0;
    volume_t upd_vol = '0;
    logic    o_upd_rdy;
    logic    o_lut_vld_r;
    id_t     o_lut_prod_id_r;
    level_t  o_lut_level_r;
    logic    o_upd_vld_r;
    id_t     o_upd_prod_id_r;
    cmd_t    o_upd_cmd_r;
    key_t    o_upd_key_r;
    volume_t o_upd_volume_r;
    logic    o_busy;

    v_state_arb #(.UPD_FIFO_N(FN), .STARVE_N(SN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_qry_vld       (qry_vld),
        .i_qry_prod_id   (qry_id),
        .i_qry_level     (qry_level),
        .o_qry_rdy       (o_qry_rdy),
        .i_upd_vld       (upd_vld),
        .i_upd_prod_id   (upd_id),
        .i_upd_cmd       (upd_cmd),
        .i_upd_key       (upd_key),
        .i_upd_volume    (upd_vol),
        .o_upd_rdy       (o_upd_rdy),
        .o_lut_vld_r     (o_lut_vld_r),
        .o_lut_prod_id_r (o_lut_prod_id_r),
        .o_lut_level_r   (o_lut_level_r),
        .o_upd_vld_r     (o_upd_vld_r),
        .o_upd_prod_id_r (o_upd_prod_id_r),
        .o_upd_cmd_r     (o_upd_cmd_r),
        .o_upd_key_r     (o_upd_key_r),
        .o_upd_volume_r  (o_upd_volume_r),
        .o_busy          (o_busy)
    );

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit q_hold = 1'b0;
    bit u_hold = 1'b0;
    int upd_wait = 0;
    logic [LW-1:0] exp_lut_q[$];
    logic [UW-1:0] exp_upd_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Holds payload and valid while a previous offer is still waiting for rdy.
    task automatic drive(input bit qv, input bit uv);
        @(negedge clk);
        if (!q_hold) begin
            qry_id    = id_t'($urandom_range(0, 255));
            qry_level = level_t'($urandom_range(0, 15));
        end
        if (!u_hold) begin
            upd_id  = id_t'($urandom_range(0, 255));
            upd_cmd = cmd_t'($urandom_range(0, 3));
            upd_key = key_t'($urandom_range(0, 65535));
            upd_vol = volume_t'($urandom());
        end
        qry_vld = qv | q_hold;
        upd_vld = uv | u_hold;
        #1;
        q_hold = qry_vld && !o_qry_rdy;
        u_hold = upd_vld && !o_upd_rdy;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        #4;
        if (rst_n) begin
            if (qry_vld && o_qry_rdy) exp_lut_q.push_back({qry_id, qry_level});
            if (upd_vld && o_upd_rdy) exp_upd_q.push_back({upd_id, upd_cmd, upd_key, upd_vol});
        end
    end

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("issue_overlap", 64'(o_lut_vld_r & o_upd_vld_r), 64'(0));
            if (o_lut_vld_r) begin
                check("lut_expected", 64'(exp_lut_q.size() != 0), 64'(1));
                if (exp_lut_q.size() != 0)
                    check("lut_payload", 64'({o_lut_prod_id_r, o_lut_level_r}), 64'(exp_lut_q.pop_front()));
            end
            if (o_upd_vld_r) begin
                check("upd_expected", 64'(exp_upd_q.size() != 0), 64'(1));
                if (exp_upd_q.size() != 0)
                    check("upd_payload", 64'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_volume_r}),
                          64'(exp_upd_q.pop_front()));
            end
            if (o_upd_vld_r || exp_upd_q.size() == 0) upd_wait = 0;
            else upd_wait++;
            check("upd_wait_bound", 64'(upd_wait <= SN), 64'(1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout watchdog expired");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_lut_vld", 64'(o_lut_vld_r), 64'(0));
        check("rst_upd_vld", 64'(o_upd_vld_r), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_upd_rdy", 64'(o_upd_rdy), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // single query id=5 level=2
        drive(1, 0);
        qry_id = 8'd5;
        qry_level = 4'd2;
        check("t1_qry_rdy", 64'(o_qry_rdy), 64'(1));
        drive(0, 0);
        check("t1_lut_vld", 64'(o_lut_vld_r), 64'(1));
        check("t1_lut_id", 64'(o_lut_prod_id_r), 64'(5));
        check("t1_lut_level", 64'(o_lut_level_r), 64'(2));
        check("t1_upd_vld", 64'(o_upd_vld_r), 64'(0));
        drive(0, 0);
        check("t1_lut_drop", 64'(o_lut_vld_r), 64'(0));

        // single update id=3, minimum latency and busy tail
        drive(0, 1);
        upd_id = 8'd3;
        check("t2_upd_rdy", 64'(o_upd_rdy), 64'(1));
        drive(0, 0);
        check("t2_upd_vld_n1", 64'(o_upd_vld_r), 64'(0));
        check("t2_busy_n1", 64'(o_busy), 64'(1));
        drive(0, 0);
        check("t2_upd_vld_n2", 64'(o_upd_vld_r), 64'(1));
        check("t2_upd_id", 64'(o_upd_prod_id_r), 64'(3));
        drive(0, 0);
        check("t2_upd_vld_n3", 64'(o_upd_vld_r), 64'(0));
        check("t2_busy_n3", 64'(o_busy), 64'(0));

        // continuous queries, one update: 8 queries win, then one forced update slot
        drive(1, 1);
        check("t3_qry_rdy_0", 64'(o_qry_rdy), 64'(1));
        for (int c = 1; c < 10; c++) begin
            drive(1, 0);
            check("t3_qry_rdy", 64'(o_qry_rdy), 64'(c != 8));
            check("t3_lut_vld", 64'(o_lut_vld_r), 64'(c != 9));
            check("t3_upd_vld", 64'(o_upd_vld_r), 64'(c == 9));
        end
        repeat (3) drive(0, 0);

        // fill the FIFO under saturating queries; forced pop does not free a slot that cycle
        for (int c = 0; c < 10; c++) begin
            drive(1, c <= 4);
            check("t4_upd_rdy", 64'(o_upd_rdy), 64'(c <= 3 || c == 9));
            check("t4_qry_rdy", 64'(o_qry_rdy), 64'(c != 8));
        end
        repeat (2) drive(1, 0);
        repeat (10) drive(0, 0);
        check("t4_busy_idle", 64'(o_busy), 64'(0));
        check("t4_upd_drained", 64'(exp_upd_q.size()), 64'(0));

        // async reset with 3 updates queued and a query in flight
        repeat (3) drive(1, 1);
        drive(1, 0);
        check("t5_lut_pre", 64'(o_lut_vld_r), 64'(1));
        check("t5_busy_pre", 64'(o_busy), 64'(1));
        rst_n = 1'b0;
        qry_vld = 1'b0;
        upd_vld = 1'b0;
        q_hold = 1'b0;
        u_hold = 1'b0;
        exp_lut_q.delete();
        exp_upd_q.delete();
        #1;
        check("t5_lut_rst", 64'(o_lut_vld_r), 64'(0));
        check("t5_upd_rst", 64'(o_upd_vld_r), 64'(0));
        check("t5_busy_rst", 64'(o_busy), 64'(0));
        check("t5_rdy_rst", 64'(o_upd_rdy), 64'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) drive(0, 0);
        check("t5_busy_post", 64'(o_busy), 64'(0));

        // random valid/ready stress
        for (int i = 0; i < 10000; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        repeat (FN + 6) drive(0, 0);
        check("t6_lut_drained", 64'(exp_lut_q.size()), 64'(0));
        check("t6_upd_drained", 64'(exp_upd_q.size()), 64'(0));
        check("t6_busy_idle", 64'(o_busy), 64'(0));

        // ---------------- report ----------------
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
